// File: rtl/pipe_ce_ctrl_pkg.sv
// Shared types for the pipe_ce_ctrl clock-enable controller.
// Holds the FSM state encoding and the in-flight counter width.
package pipe_ce_ctrl_pkg;
  localparam int INFLIGHT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;
endpackage

// File: rtl/pipe_ce_ctrl_fifo.sv
// Output skid FIFO: register-array storage, head read straight from registers, sync clear wins over push/pop.
// Latency 1 (push edge to o_empty=0); a push on a full FIFO is only taken with a same-cycle pop.
module pipe_ce_ctrl_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_clr,
  input  logic                      i_push,
  input  logic [DW-1:0]             i_dat,
  input  logic                      i_pop,
  output logic [DW-1:0]             o_dat,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_pop;
  logic          w_push;

  assign w_pop  = i_pop && (r_cnt != '0);
  assign w_push = i_push && ((r_cnt != CW'(DEPTH)) || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_clr) r_mem[r_wp] <= i_dat;
  end

  assign o_dat   = r_mem[r_rp];
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_cnt   = r_cnt;
endmodule

// File: rtl/pipe_ce_ctrl.sv
// Clock-enable/flush controller for a C_LATENCY-stage datapath with output skid FIFO; optional PIPE_CE_CTRL_STATS_EN adds stall/accept counters.
// Accept-to-out_valid latency C_LATENCY; pipe_ce and in_ready drop when the tail word cannot enter a full, un-popped FIFO.
module pipe_ce_ctrl
  import pipe_ce_ctrl_pkg::*;
#(
  parameter int C_LATENCY    = 4,
  parameter int C_DATA_WIDTH = 16,
  parameter int C_FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    pipe_ce,
  output logic                    pipe_flush,
  input  logic [C_DATA_WIDTH-1:0] pipe_out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [C_DATA_WIDTH-1:0] out_data,
  input  logic                    flush_req,
  input  logic                    drain_req,
  output logic                    drain_done,
  output logic                    busy,
  output logic [INFLIGHT_W-1:0]   inflight_cnt
`ifdef PIPE_CE_CTRL_STATS_EN
  ,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             accept_cnt
`endif
);
  state_t                       r_state;
  logic [C_LATENCY-1:0]         r_vchain;
  logic [INFLIGHT_W-1:0]        r_inflight;
  logic                         r_drain_done;
  logic                         w_tail;
  logic                         w_full;
  logic                         w_empty;
  logic [$clog2(C_FIFO_DEPTH):0] w_cnt;
  logic                         w_pop;
  logic                         w_push;
  logic                         w_accept;
  logic                         w_ce;
  logic                         w_quiet;

  assign w_tail = r_vchain[C_LATENCY-1];
  assign w_pop  = !w_empty && out_ready;

  // Stall only when the tail word has nowhere to go this cycle.
  always_comb begin
    w_ce = 1'b1;
    if (r_state == ST_FLUSH)                 w_ce = 1'b0;
    else if (w_tail && w_full && !w_pop)     w_ce = 1'b0;
  end

  assign pipe_ce    = w_ce;
  assign in_ready   = w_ce && (r_state == ST_IDLE || r_state == ST_RUN);
  assign w_accept   = in_valid && in_ready;
  assign w_push     = w_tail && w_ce;
  assign w_quiet    = (r_inflight == '0) && (w_cnt == '0) && !w_accept;
  assign pipe_flush = (r_state == ST_FLUSH);
  assign busy       = (r_state != ST_IDLE);
  assign drain_done = r_drain_done;
  assign inflight_cnt = r_inflight;
  assign out_valid  = !w_empty;

  pipe_ce_ctrl_fifo #(
    .DW    (C_DATA_WIDTH),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (flush_req),
    .i_push  (w_push),
    .i_dat   (pipe_out_data),
    .i_pop   (w_pop),
    .o_dat   (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_cnt   (w_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_vchain     <= '0;
      r_inflight   <= '0;
      r_drain_done <= 1'b0;
    end else if (flush_req) begin
      r_state      <= ST_FLUSH;
      r_vchain     <= '0;
      r_inflight   <= '0;
      r_drain_done <= 1'b0;
    end else begin
      r_drain_done <= 1'b0;
      if (w_ce) r_vchain <= (r_vchain << 1) | C_LATENCY'(w_accept);
      case ({w_accept, w_push})
        2'b10:   r_inflight <= r_inflight + INFLIGHT_W'(1);
        2'b01:   r_inflight <= r_inflight - INFLIGHT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (drain_req) begin
            r_state      <= w_quiet ? ST_IDLE : ST_DRAIN;
            r_drain_done <= w_quiet;
          end else if (w_accept) begin
            r_state <= ST_RUN;
          end else if (w_quiet) begin
            r_state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (w_quiet) begin
            r_state      <= ST_IDLE;
            r_drain_done <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef PIPE_CE_CTRL_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_accept_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt  <= '0;
      r_accept_cnt <= '0;
    end else if (flush_req) begin
      r_stall_cnt  <= '0;
      r_accept_cnt <= '0;
    end else begin
      if (w_tail && !w_ce && (r_stall_cnt != '1)) r_stall_cnt  <= r_stall_cnt + 32'd1;
      if (w_accept && (r_accept_cnt != '1))       r_accept_cnt <= r_accept_cnt + 32'd1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign accept_cnt = r_accept_cnt;
`endif
endmodule

// File: tb/tb_pipe_ce_ctrl.sv
// Bench for pipe_ce_ctrl: token-level model (slot array + FIFO queue) checked every cycle, plus directed scenarios.
`timescale 1ns/1ps
module tb_pipe_ce_ctrl;
  localparam int L  = 4;
  localparam int DW = 16;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          pipe_ce;
  logic          pipe_flush;
  logic [DW-1:0] pipe_out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          flush_req = 1'b0;
  logic          drain_req = 1'b0;
  logic          drain_done;
  logic          busy;
  logic [6:0]    inflight_cnt;
  logic [DW-1:0] in_data = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_ce_ctrl #(.C_LATENCY(L), .C_DATA_WIDTH(DW), .C_FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pipe_ce(pipe_ce), .pipe_flush(pipe_flush), .pipe_out_data(pipe_out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush_req(flush_req), .drain_req(drain_req), .drain_done(drain_done),
    .busy(busy), .inflight_cnt(inflight_cnt)
  );

  // Controlled datapath: plain ce-gated delay line, never reset.
  logic [DW-1:0] dp [L];
  always @(posedge clk) begin
    if (pipe_flush) begin
      for (int i = 0; i < L; i++) dp[i] <= '0;
    end else if (pipe_ce) begin
      dp[0] <= in_data;
      for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
    end
  end
  assign pipe_out_data = dp[L-1];

  typedef struct { bit v; logic [DW-1:0] d; } slot_t;
  typedef enum {M_IDLE, M_RUN, M_DRAIN, M_FLUSH} mmode_t;

  slot_t         m_pipe [L];
  logic [DW-1:0] m_fifo [$];
  mmode_t        m_mode;
  bit            m_dd;
  logic [DW-1:0] tx [$];
  logic [DW-1:0] rx [$];

  logic          last_ov, last_ce, last_ir, last_dd, last_pf, last_busy;
  logic [DW-1:0] last_od;
  logic [6:0]    last_inf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_inflight();
    int n = 0;
    for (int i = 0; i < L; i++) if (m_pipe[i].v) n++;
    return n;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < L; i++) m_pipe[i].v = 1'b0;
    m_fifo.delete();
    m_mode = M_IDLE;
    m_dd   = 1'b0;
  endtask

  // One clock: drive inputs, check all outputs against the model, then advance the model.
  task automatic cycle(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl, input bit dr);
    bit e_pop, e_ce, e_ir, e_acc, e_push, quiet;
    int n_in;
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; flush_req = fl; drain_req = dr;
    #1;
    e_pop  = (m_fifo.size() > 0) && ordy;
    e_ce   = (m_mode == M_FLUSH) ? 1'b0 : !(m_pipe[L-1].v && m_fifo.size() == D && !e_pop);
    e_ir   = (m_mode == M_IDLE || m_mode == M_RUN) && e_ce;
    e_acc  = iv && e_ir;
    e_push = m_pipe[L-1].v && e_ce;
    n_in   = m_inflight();
    chk("pipe_ce", pipe_ce, e_ce);
    chk("in_ready", in_ready, e_ir);
    chk("out_valid", out_valid, m_fifo.size() > 0);
    if (m_fifo.size() > 0) chk("out_data", out_data, m_fifo[0]);
    chk("inflight_cnt", inflight_cnt, n_in);
    chk("busy", busy, m_mode != M_IDLE);
    chk("pipe_flush", pipe_flush, m_mode == M_FLUSH);
    chk("drain_done", drain_done, m_dd);
    last_ov = out_valid; last_ce = pipe_ce; last_ir = in_ready; last_dd = drain_done;
    last_pf = pipe_flush; last_busy = busy; last_od = out_data; last_inf = inflight_cnt;
    if (out_valid && ordy) rx.push_back(out_data);
    if (e_acc) tx.push_back(d);
    @(posedge clk);
    if (fl) begin
      m_reset();
      m_mode = M_FLUSH;
    end else begin
      quiet = (n_in == 0) && (m_fifo.size() == 0) && !e_acc;
      if (e_pop) void'(m_fifo.pop_front());
      if (e_push) m_fifo.push_back(m_pipe[L-1].d);
      if (e_ce) begin
        for (int i = L-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0].v = e_acc;
        m_pipe[0].d = d;
      end
      m_dd = 1'b0;
      case (m_mode)
        M_IDLE, M_RUN: begin
          if (dr) begin
            m_dd   = quiet;
            m_mode = quiet ? M_IDLE : M_DRAIN;
          end else if (e_acc) m_mode = M_RUN;
          else if (quiet)     m_mode = M_IDLE;
        end
        M_DRAIN: if (quiet) begin m_mode = M_IDLE; m_dd = 1'b1; end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  initial begin
    int n;
    m_reset();
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_inflight", inflight_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pipe_ce", pipe_ce, 1);
    @(negedge clk);
    rst = 1'b1;

    // Single word 0x00A5: latency and in-flight count.
    cycle(1, 16'h00A5, 1, 0, 0);
    cycle(0, 16'h0, 1, 0, 0);
    chk("s1_inflight_one", last_inf, 1);
    n = 1;
    while (!last_ov && n < 20) begin
      cycle(0, 16'h0, 1, 0, 0);
      n++;
    end
    chk("s1_latency", n - 1, L);
    chk("s1_data", last_od, 16'h00A5);
    chk("s1_inflight_zero", last_inf, 0);
    repeat (3) cycle(0, 16'h0, 1, 0, 0);

    // Stream 10 words into a blocked output, then release.
    tx.delete(); rx.delete();
    for (int c = 0; c < 20; c++) cycle(tx.size() < 10, 16'h0100 + 16'(tx.size()), 0, 0, 0);
    chk("s2_ce_stalled", last_ce, 0);
    chk("s2_in_ready_low", last_ir, 0);
    chk("s2_inflight_full", last_inf, L);
    chk("s2_accepted", tx.size(), L + D);
    for (int c = 0; c < 60 && rx.size() < 10; c++)
      cycle(tx.size() < 10, 16'h0100 + 16'(tx.size()), 1, 0, 0);
    chk("s2_rx_count", rx.size(), 10);
    for (int i = 0; i < 10 && i < rx.size(); i++) chk("s2_order", rx[i], tx[i]);
    repeat (3) cycle(0, 16'h0, 1, 0, 0);

    // Drain with three words in flight.
    repeat (3) cycle(1, 16'($urandom), 1, 0, 0);
    cycle(0, 16'h0, 1, 0, 1);
    chk("s3_inflight", last_inf, 3);
    cycle(1, 16'h0, 1, 0, 0);
    chk("s3_in_ready_low", last_ir, 0);
    n = 0;
    while (!last_dd && n < 30) begin
      cycle(1, 16'h0, 1, 0, 0);
      n++;
    end
    chk("s3_drain_done", last_dd, 1);
    chk("s3_idle", last_busy, 0);
    repeat (8) cycle(0, 16'h0, 1, 0, 0);

    // Flush with FIFO and chain both full.
    for (int c = 0; c < 20; c++) cycle(1, 16'($urandom), 0, 0, 0);
    chk("s4_prefill_ov", last_ov, 1);
    cycle(0, 16'h0, 0, 1, 0);
    cycle(0, 16'h0, 0, 0, 0);
    chk("s4_pipe_flush", last_pf, 1);
    chk("s4_out_valid", last_ov, 0);
    chk("s4_inflight", last_inf, 0);
    cycle(0, 16'h0, 1, 0, 0);
    chk("s4_pipe_flush_off", last_pf, 0);
    repeat (8) cycle(0, 16'h0, 1, 0, 0);

    // Randomized traffic with occasional flush/drain commands.
    for (int c = 0; c < 800; c++)
      cycle($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3);

    // Asynchronous reset in the middle of traffic.
    for (int c = 0; c < 10; c++) cycle(1, 16'($urandom), $urandom_range(0, 1) == 1, 0, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_inflight", inflight_cnt, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_drain_done", drain_done, 0);
    chk("rst2_pipe_flush", pipe_flush, 0);
    chk("rst2_pipe_ce", pipe_ce, 1);
    chk("rst2_in_ready", in_ready, 1);
    in_valid = 1'b0;
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (12) cycle(0, 16'($urandom), 1, 0, 0);
    chk("rst2_no_output", last_ov, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
